// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for a RISC-V core: watches write-back to x3/x26/x27 and
// registers a pass/fail/timeout verdict once the test signals completion.
module riscv_test_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned SETTLE_CYCLES  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic [31:0] fail_inst_o,
    output logic [31:0] cycle_cnt_o,
    output logic [1:0]  state_o
);

    // done_o acts as a sticky valid: the verdict fields are stable from the
    // cycle done_o rises until reset; there is no ready, the consumer samples.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2,
        ST_TMO    = 2'd3
    } state_t;

    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [31:0] s3_q, s26_q, s27_q;
    logic [31:0] cycle_cnt_q;
    logic [31:0] settle_cnt_q;
    logic        done_q, pass_q, fail_q, timeout_q;
    logic [31:0] fail_inst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            s3_q         <= '0;
            s26_q        <= '0;
            s27_q        <= '0;
            cycle_cnt_q  <= '0;
            settle_cnt_q <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_inst_q  <= '0;
        end else begin
            // Shadows track write-back until a verdict is latched.
            if ((state_q == ST_RUN || state_q == ST_SETTLE) && we_i) begin
                case (waddr_i)
                    5'd3:    s3_q  <= wdata_i;
                    5'd26:   s26_q <= wdata_i;
                    5'd27:   s27_q <= wdata_i;
                    default: ;
                endcase
            end

            case (state_q)
                ST_RUN: begin
                    if (cycle_cnt_q != 32'hFFFF_FFFF) begin
                        cycle_cnt_q <= cycle_cnt_q + 32'd1;
                    end
                    if (s26_q == 32'h1) begin
                        state_q      <= ST_SETTLE;
                        settle_cnt_q <= '0;
                    end else if (cycle_cnt_q == TMO_LAST) begin
                        state_q     <= ST_TMO;
                        done_q      <= 1'b1;
                        timeout_q   <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_inst_q <= s3_q;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        pass_q      <= (s27_q == 32'h1);
                        fail_q      <= (s27_q != 32'h1);
                        timeout_q   <= 1'b0;
                        fail_inst_q <= s3_q;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign fail_inst_o = fail_inst_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: expected verdicts queued by the
// stimulus, compared by a monitor when done_o rises.
module tb_riscv_test_monitor;

  localparam int TMO = 50;
  localparam int SET = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        done, pass, fail, tmo;
  logic [31:0] fail_inst, cycle_cnt;
  logic [1:0]  state;

  riscv_test_monitor #(.TIMEOUT_CYCLES(TMO), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .done_o(done), .pass_o(pass), .fail_o(fail), .timeout_o(tmo),
    .fail_inst_o(fail_inst), .cycle_cnt_o(cycle_cnt), .state_o(state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int edge_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;
  end

  typedef struct packed {
    logic        p;
    logic        f;
    logic        t;
    logic [31:0] inst;
    logic [31:0] cc;
    logic [31:0] edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic f, input logic t,
                          input logic [31:0] inst, input logic [31:0] cc, input int e);
    exp_t x;
    x.p = p; x.f = f; x.t = t; x.inst = inst; x.cc = cc; x.edge_n = 32'(e);
    exp_q.push_back(x);
  endtask

  // driver tasks; all are entered and left on a falling edge
  task automatic do_reset();
    rst = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    done_seen = 1'b0;
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_fail", {31'd0, fail}, 32'd0);
    check("rst_tmo", {31'd0, tmo}, 32'd0);
    check("rst_inst", fail_inst, 32'd0);
    check("rst_cc", cycle_cnt, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // write sampled by the rising edge numbered e since reset release
  task automatic wr_at(input int e, input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    while (edge_cnt != e - 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      errors++;
      $display("FAIL wr_wait: edge %0d never reached", e);
    end
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic wait_edge(input int e);
    int n = 0;
    while (edge_cnt != e && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_seen && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_wait: done_o %0b after %0d cycles, required 1", done, n);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst && done && !done_seen) begin
      done_seen = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: verdict at edge %0d with empty queue", edge_cnt);
      end else begin
        e = exp_q.pop_front();
        check("pass", {31'd0, pass}, {31'd0, e.p});
        check("fail", {31'd0, fail}, {31'd0, e.f});
        check("timeout", {31'd0, tmo}, {31'd0, e.t});
        check("fail_inst", fail_inst, e.inst);
        check("cycle_cnt", cycle_cnt, e.cc);
        check("done_edge", 32'(edge_cnt), e.edge_n);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);

    // pass: x27=1, x26=1 at edge 40 -> settle at 41, done at 46
    do_reset();
    push_exp(1'b1, 1'b0, 1'b0, 32'd0, 32'd41, 46);
    wr_at(10, 5'd27, 32'd1);
    wr_at(40, 5'd26, 32'd1);
    wait_done();

    // fail with test number, non-1 x26 ignored, post-verdict writes ignored
    do_reset();
    push_exp(1'b0, 1'b1, 1'b0, 32'd7, 32'd9, 14);
    wr_at(3, 5'd26, 32'd2);
    wr_at(5, 5'd3, 32'd7);
    wr_at(6, 5'd27, 32'd0);
    wr_at(8, 5'd26, 32'd1);
    wait_done();
    wr_at(edge_cnt + 1, 5'd27, 32'd1);
    wr_at(edge_cnt + 1, 5'd3, 32'd99);
    repeat (5) @(negedge clk);
    check("sticky_fail", {31'd0, fail}, 32'd1);
    check("sticky_pass", {31'd0, pass}, 32'd0);
    check("frozen_inst", fail_inst, 32'd7);
    check("frozen_cc", cycle_cnt, 32'd9);
    check("done_state", {30'd0, state}, 32'd2);

    // late x27 write during settle, x26 cleared during settle
    do_reset();
    push_exp(1'b1, 1'b0, 1'b0, 32'd0, 32'd11, 16);
    wr_at(10, 5'd26, 32'd1);
    wr_at(12, 5'd27, 32'd1);
    wr_at(13, 5'd26, 32'd0);
    wait_done();

    // x27=2 fails; x3 written during settle is captured
    do_reset();
    push_exp(1'b0, 1'b1, 1'b0, 32'd9, 32'd5, 10);
    wr_at(3, 5'd27, 32'd2);
    wr_at(4, 5'd26, 32'd1);
    wr_at(6, 5'd3, 32'd9);
    wait_done();

    // timeout; writes to x0 and x25 have no effect
    do_reset();
    push_exp(1'b0, 1'b0, 1'b1, 32'd0, 32'd50, 50);
    wr_at(5, 5'd0, 32'd1);
    wr_at(6, 5'd25, 32'd1);
    wait_done();
    check("tmo_state", {30'd0, state}, 32'd3);

    // s26 reaches 1 exactly at the timeout cycle: settle wins
    do_reset();
    push_exp(1'b1, 1'b0, 1'b0, 32'd0, 32'd50, 55);
    wr_at(2, 5'd27, 32'd1);
    wr_at(49, 5'd26, 32'd1);
    wait_done();

    // reset at settle cycle 2, then a fresh run
    do_reset();
    wr_at(2, 5'd27, 32'd1);
    wr_at(4, 5'd26, 32'd1);
    wait_edge(7);
    check("mid_settle_state", {30'd0, state}, 32'd1);
    check("mid_settle_cc", cycle_cnt, 32'd5);
    do_reset();
    push_exp(1'b1, 1'b0, 1'b0, 32'd0, 32'd4, 9);
    wr_at(2, 5'd27, 32'd1);
    wr_at(3, 5'd26, 32'd1);
    wait_done();

    do_reset();
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 5000, the RUN cycles allowed before a timeout is declared.
REQ-002 The module SHALL have parameter SETTLE_CYCLES, default 5, the cycles waited after the end-of-test marker before the verdict is sampled; legal range is 1 or more.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; 0 = in reset.
REQ-005 we_i  input  1  core register-file write enable from write-back.
REQ-006 waddr_i  input  5  register-file write address.
REQ-007 wdata_i  input  32  register-file write data.
REQ-008 done_o  output  1  verdict available (pass, fail or timeout); sticky.
REQ-009 pass_o  output  1  test passed.
REQ-010 fail_o  output  1  test failed.
REQ-011 timeout_o  output  1  end marker never seen within TIMEOUT_CYCLES.
REQ-012 fail_inst_o  output  32  shadow x3 captured at verdict: the failing test number.
REQ-013 cycle_cnt_o  output  32  RUN cycles elapsed; frozen once SETTLE is entered.

Function
REQ-014 The module SHALL keep shadow registers s3, s26 and s27, each updated one cycle after a write with we_i=1 and waddr_i equal to 3, 26 or 27 respectively.
REQ-015 The module SHALL ignore writes with waddr_i=0 and writes to any other address.
REQ-016 The module SHALL implement the states RUN, SETTLE, DONE and TMO, with RUN entered on reset release.
REQ-017 In RUN, cycle_cnt SHALL increment by 1 per cycle, saturating at 32'hFFFF_FFFF.
REQ-018 RUN SHALL go to SETTLE when s26 == 32'h1 (registered shadow); other s26 values SHALL have no effect.
REQ-019 RUN SHALL go to TMO when cycle_cnt == TIMEOUT_CYCLES-1 and the RUN->SETTLE condition is false.
REQ-020 When the RUN->SETTLE and RUN->TMO conditions are true in the same cycle, SETTLE SHALL win.
REQ-021 On SETTLE entry the settle counter SHALL load 0, then increment each cycle.
REQ-022 While in SETTLE, the shadow registers SHALL keep updating.
REQ-023 The module SHALL NOT apply the timeout in SETTLE.
REQ-024 SETTLE SHALL go to DONE in the cycle where settle_cnt == SETTLE_CYCLES-1.
REQ-025 On the SETTLE->DONE edge the module SHALL register done_o=1, pass_o=(s27==32'h1), fail_o=!pass_o and fail_inst_o=s3.
REQ-026 A value of s27 other than exactly 1, including 0 or 2, SHALL produce fail_o=1.
REQ-027 Once SETTLE is entered, the module SHALL complete the verdict even if x26 is rewritten to 0 during SETTLE.
REQ-028 On the RUN->TMO edge the module SHALL register done_o=1, timeout_o=1, pass_o=0, fail_o=0 and fail_inst_o=s3.
REQ-029 DONE and TMO SHALL be terminal until reset, with all outputs frozen and later writes ignored.
REQ-030 pass_o, fail_o and timeout_o SHALL be mutually exclusive and SHALL be 0 whenever done_o=0.
REQ-031 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-032 When rst=0, the module SHALL asynchronously force state=RUN and clear s3, s26, s27, cycle_cnt, settle_cnt, done_o, pass_o, fail_o, timeout_o and fail_inst_o to 0.
REQ-033 Reset asserted in any state, including mid-SETTLE or DONE, SHALL abort the run.
REQ-034 After rst returns to 1, counting SHALL begin from the first rising clk edge.

Verification
REQ-035 Pass: write x27=1, then x26=1 at RUN cycle 40 -> done_o=1 exactly 1+SETTLE_CYCLES cycles after the x26 write edge; pass_o=1, fail_o=0, timeout_o=0; cycle_cnt_o=41.
REQ-036 Fail: write x3=7, x27=0, then x26=1 -> done_o=1, fail_o=1, pass_o=0, fail_inst_o=7.
REQ-037 Late write: x26=1 with x27=0, then x27=1 written 2 cycles later (SETTLE_CYCLES=5) -> pass_o=1.
REQ-038 Write x27=1 after the verdict -> fail_o remains 1.
REQ-039 Timeout: TIMEOUT_CYCLES=50 with no x26 write -> timeout_o=1 and done_o=1 on the 50th RUN cycle; pass_o=fail_o=0.
REQ-040 Simultaneous: s26 becomes 1 on cycle TIMEOUT_CYCLES-1 -> SETTLE is taken and timeout_o stays 0.
REQ-041 Write x26=1 with waddr_i=0 -> no effect.
REQ-042 Assert rst at SETTLE cycle 2 -> all outputs 0 immediately, before the next clk edge; after release, a new run reaches its verdict normally.
